// File: rtl/systolic_drain1x4.sv
// ============================================================================
// Module   : systolic_drain1x4
// Purpose  : Sequences one 1x4 systolic dot-product job, snapshots the four
//            PE accumulators and drains them over a valid/ready port.
//            Optional macro SYSTOLIC_DRAIN_CLR_EN adds the arr_clr pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_drain1x4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  k_len,
    input  logic [31:0] c0,
    input  logic [31:0] c1,
    input  logic [31:0] c2,
    input  logic [31:0] c3,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [1:0]  out_idx,
    output logic        busy,
`ifdef SYSTOLIC_DRAIN_CLR_EN
    output logic        arr_clr,
`endif
    output logic        done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_FIN   = 2'd3;

    logic [1:0]  r_state;
    logic [8:0]  r_cnt;
    logic [31:0] r_shadow [4];
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [1:0]  r_out_idx;
    logic        r_done;
    logic [1:0]  w_next_idx;
    logic        w_xfer;

`ifdef SYSTOLIC_DRAIN_CLR_EN
    logic        r_arr_clr;
    assign arr_clr = r_arr_clr;
`endif

    assign w_next_idx = r_out_idx + 2'd1;
    assign w_xfer     = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 9'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_idx   <= 2'd0;
            r_done      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 32'd0;
            end
`ifdef SYSTOLIC_DRAIN_CLR_EN
            r_arr_clr   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SYSTOLIC_DRAIN_CLR_EN
            r_arr_clr <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
                    if (start && (k_len != 8'd0)) begin
                        // Counter reaches zero in cycle K+3 (start cycle is 0),
                        // when PE3's final value is on c3.
                        r_cnt   <= {1'b0, k_len} + 9'd2;
                        r_state <= c_ACCUM;
                    end
                end
                c_ACCUM: begin
                    if (r_cnt == 9'd0) begin
                        r_shadow[0] <= c0;
                        r_shadow[1] <= c1;
                        r_shadow[2] <= c2;
                        r_shadow[3] <= c3;
                        r_out_data  <= c0;
                        r_out_idx   <= 2'd0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DRAIN;
`ifdef SYSTOLIC_DRAIN_CLR_EN
                        r_arr_clr   <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                c_DRAIN: begin
                    if (w_xfer) begin
                        if (r_out_idx == 2'd3) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= c_FIN;
                        end else begin
                            r_out_idx  <= w_next_idx;
                            r_out_data <= r_shadow[w_next_idx];
                        end
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign done      = r_done;
    assign busy      = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_systolic_drain1x4.sv
// ============================================================================
// Module   : tb_systolic_drain1x4
// Purpose  : Directed self-checking bench for systolic_drain1x4.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_systolic_drain1x4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  k_len;
    logic [31:0] cv [4];
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_idx;
    logic        busy;
    logic        done;
`ifdef SYSTOLIC_DRAIN_CLR_EN
    logic        arr_clr;
`endif

    int total;
    int bad;

    systolic_drain1x4 u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .c0        (cv[0]),
        .c1        (cv[1]),
        .c2        (cv[2]),
        .c3        (cv[3]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
`ifdef SYSTOLIC_DRAIN_CLR_EN
        .arr_clr   (arr_clr),
`endif
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Each step lands 1 time unit after a rising edge: outputs are sampled
    // and inputs for the new cycle are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // PEj shows garbage until cycle K+j, then its final value; after the
    // snapshot cycle every c input changes to prove shadow isolation.
    task automatic drive_c(input int k, input int n, input logic [31:0] v [4]);
        for (int j = 0; j < 4; j++) begin
            if (n >= k + 4)
                cv[j] = 32'hDEAD0000 + 32'(n);
            else if (n >= k + j)
                cv[j] = v[j];
            else
                cv[j] = 32'hBAD00000 + 32'(j * 256 + n);
        end
    endtask

    task automatic run_job(input int k, input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3,
                           input int stall, input bit extra_start, input bit start_at_done);
        logic [31:0] v [4];
        int n, exp_idx, first, xfers, last_x, stall_left;
        bit seen_done;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        n = 0; exp_idx = 0; first = -1; xfers = 0; last_x = -1;
        stall_left = stall; seen_done = 1'b0;
        start = 1'b1; k_len = 8'(k); out_ready = 1'b1;
        drive_c(k, 0, v);
        while (!seen_done && n < 400) begin
            step();
            n++;
            start = 1'b0;
            k_len = 8'd0;
            if (extra_start && n == 2) begin
                start = 1'b1;
                k_len = 8'd1;
            end
            drive_c(k, n, v);
            check("busy_in_job", 32'(busy), 32'd1);
`ifdef SYSTOLIC_DRAIN_CLR_EN
            check("arr_clr", 32'(arr_clr), 32'(n == k + 4));
`endif
            out_ready = 1'b1;
            if (out_valid) begin
                if (first < 0) begin
                    first = n;
                    check("first_valid_cycle", 32'(n), 32'(k + 4));
                end
                if (exp_idx > 3) begin
                    check("extra_word", 32'(out_valid), 32'd0);
                end else begin
                    check("out_idx", 32'(out_idx), 32'(exp_idx));
                    check("out_data", out_data, v[exp_idx]);
                    if (exp_idx == 1 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        xfers++;
                        last_x = n;
                        exp_idx++;
                    end
                end
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_cycle", 32'(n), 32'(last_x + 1));
                check("xfer_count", 32'(xfers), 32'd4);
                if (start_at_done) begin
                    start = 1'b1;
                    k_len = 8'(k);
                end
            end
        end
        check("done_seen", 32'(seen_done), 32'd1);
        step();
        start = 1'b0;
        k_len = 8'd0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("valid_after_job", 32'(out_valid), 32'd0);
        step();
        check("idle_after_job", 32'(busy), 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        k_len = 8'd0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) cv[j] = 32'd0;
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef SYSTOLIC_DRAIN_CLR_EN
        check("rst_arr_clr", 32'(arr_clr), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Scenario 1: K=1, all PEs 5*5
        run_job(1, 32'd25, 32'd25, 32'd25, 32'd25, 0, 1'b0, 1'b0);
        // Scenario 2: K=3, PE0 = 25+100+400, PE1..3 = 5*(5+10+20)
        run_job(3, 32'd525, 32'd175, 32'd175, 32'd175, 0, 1'b0, 1'b0);
        // Scenario 3: three-cycle backpressure on idx 1
        run_job(1, 32'd25, 32'd26, 32'd27, 32'd28, 3, 1'b0, 1'b0);

        // Scenario 4: reset during drain after idx 0 transfers
        start = 1'b1;
        k_len = 8'd1;
        for (int j = 0; j < 4; j++) cv[j] = 32'd77;
        for (int n = 1; n <= 6; n++) begin
            step();
            start = 1'b0;
            k_len = 8'd0;
        end
        check("s4_pre_valid", 32'(out_valid), 32'd1);
        check("s4_pre_idx", 32'(out_idx), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s4_valid", 32'(out_valid), 32'd0);
        check("s4_busy", 32'(busy), 32'd0);
        check("s4_done", 32'(done), 32'd0);
        for (int n = 0; n < 5; n++) begin
            step();
            check("s4_no_done", 32'(done), 32'd0);
            check("s4_no_valid", 32'(out_valid), 32'd0);
        end
        run_job(1, 32'd9, 32'd8, 32'd7, 32'd6, 0, 1'b0, 1'b0);

        // Scenario 5: start during ACCUM and start at done both ignored
        run_job(2, 32'd1, 32'd2, 32'd3, 32'd4, 0, 1'b1, 1'b1);
        start = 1'b1;
        k_len = 8'd0;
        step();
        start = 1'b0;
        check("s5_k0_busy", 32'(busy), 32'd0);
        for (int n = 0; n < 8; n++) begin
            step();
            check("s5_k0_valid", 32'(out_valid), 32'd0);
        end

        // Scenario 6: K=2 with distinctive bit patterns and late c changes
        run_job(2, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'h80000001, 0, 1'b0, 1'b0);
        // Longest job: K=255 exercises the full counter range
        run_job(255, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/systolic_drain1x4.md
SYSTOLIC_DRAIN1X4 -- requirements
Module: systolic_drain1x4

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: job request, sampled in the same cycle the first a/b operand pair is presented to the 1x4 array.
REQ-004 The block SHALL have the port k_len, input, 8 bits: dot-product length K (number of operand pairs), sampled with start.
REQ-005 The block SHALL have the ports c0, c1, c2, c3, input, 32 bits each: accumulator outputs of PE0..PE3 of the 1x4 array.
REQ-006 The block SHALL have the port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: out_data/out_idx valid.
REQ-008 The block SHALL have the port out_data, output, 32 bits: drained accumulator value.
REQ-009 The block SHALL have the port out_idx, output, 2 bits: PE index of out_data.
REQ-010 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have the port done, output, 1 bit: one-cycle pulse at job completion.
REQ-012 The block SHALL have the port arr_clr, output, 1 bit: array clear request; present only with DRAIN_CLR_EN.

Function
REQ-013 The block SHALL implement the states IDLE, ACCUM, DRAIN and FIN.
REQ-014 In IDLE, start=1 with k_len!=0 SHALL latch K, load the cycle counter and enter ACCUM; start with k_len==0 SHALL be ignored.
REQ-015 Cycle numbering SHALL count the start cycle as cycle 0, so PEj's final value is visible on cj in cycle K+j.
REQ-016 In the cycle K+3 edge, ACCUM SHALL snapshot c0..c3 into four 32-bit shadow registers and enter DRAIN; counter width SHALL cover K+3=258.
REQ-017 out_valid SHALL first rise in cycle K+4, carrying shadow[0] with out_idx=0.
REQ-018 In DRAIN, a word SHALL transfer only when out_valid and out_ready are both high; after each transfer the next index follows in the next cycle, order 0,1,2,3.
REQ-019 While out_ready is low, out_data and out_idx SHALL hold stable and out_valid SHALL stay high.
REQ-020 After the transfer of idx 3, out_valid SHALL drop and the block SHALL enter FIN, assert done for exactly one cycle, then return to IDLE.
REQ-021 start SHALL be ignored whenever busy=1; a start in the same cycle as done SHALL also be ignored.
REQ-022 Shadow registers SHALL be isolated from changes on c0..c3 after the snapshot.
REQ-023 The block SHALL perform no arithmetic on the data: out_data SHALL equal the snapshot bits exactly.

Reset
REQ-024 When rst=1 at an edge, the block SHALL go to IDLE and clear the counter, shadow registers, out_valid, out_data, out_idx, busy, done and arr_clr to 0.
REQ-025 A reset in ACCUM or DRAIN SHALL abort the job: out_valid SHALL be 0 in the cycle after the reset edge, with no done pulse.

Configuration
REQ-026 With macro SYSTOLIC_DRAIN_CLR_EN defined, arr_clr SHALL pulse high for exactly the one cycle following the snapshot edge (cycle K+4), so the array can start the next job while draining.
REQ-027 Without SYSTOLIC_DRAIN_CLR_EN, the arr_clr port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Scenario 1: K=1, a0..a3=5, b0=5, out_ready=1 -> words 25,25,25,25 with idx 0,1,2,3 in cycles 5..8, and done in cycle 9.
REQ-029 Scenario 2: K=3, a0/b0=(5,5),(10,10),(20,20), a1..a3=5 held -> words 525,175,175,175.
REQ-030 Scenario 3: scenario 1 with out_ready low for 3 cycles while idx 1 is pending -> idx 1 value held stable, still exactly 4 transfers, done one cycle after the last.
REQ-031 Scenario 4: rst pulsed during DRAIN after idx 0 -> out_valid=0 next cycle, busy=0, no done; a new start then runs normally.
REQ-032 Scenario 5: start during ACCUM, and start with k_len=0 in IDLE -> both ignored, no extra output words.
REQ-033 Scenario 6 (SYSTOLIC_DRAIN_CLR_EN): K=2 -> arr_clr high only in cycle 6; changing c0..c3 afterwards does not alter the drained words.
